moore_seq_detector: RTL

Parametrised successor to the team's fixed-pattern Moore machine: a runtime-programmable serial sequence detector with configurable pattern width, per-bit don't-care mask, overlap/non-overlap mode and a saturating match counter. It consumes a qualified serial bit stream and raises a registered, Moore-style detect pulse. It sits behind the TinyTapeout top-level wrapper, which maps config and stream onto ui_in/uio_in and the outputs onto uo_out.

---
 rtl/moore_det_pkg.sv | 16 +
 rtl/moore_det_window.sv | 52 +++++
 rtl/moore_seq_detector.sv | 114 +++++++++++
 3 files changed

// File: rtl/moore_det_pkg.sv
// Shared types and helpers for the programmable Moore sequence detector.
package moore_det_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        ARMED = 2'd2,
        HIT   = 2'd3
    } state_t;

    // Width needed to count 0..pat_w inclusive.
    function automatic int fill_width(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

endpackage

// File: rtl/moore_det_window.sv
// Serial shift window with a saturating fill counter and masked pattern
// comparator. Match/full are computed on the post-shift window so the FSM
// can step straight to HIT on the completing bit.
module moore_det_window
    import moore_det_pkg::*;
#(
    parameter int PAT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift,
    input  logic             bit_in,
    input  logic             clr_window,
    input  logic             clr_fill,
    input  logic [PAT_W-1:0] pattern,
    input  logic [PAT_W-1:0] mask,
    output logic             match_next,
    output logic             full_next
);

    localparam int             FW   = fill_width(PAT_W);
    localparam logic [FW-1:0]  FULL = FW'(PAT_W);

    logic [PAT_W-1:0] window;
    logic [PAT_W-1:0] window_next;
    logic [FW-1:0]    fill;
    logic [FW-1:0]    fill_next;

    assign window_next = shift ? {window[PAT_W-2:0], bit_in} : window;
    assign fill_next   = (shift && (fill != FULL)) ? fill + FW'(1) : fill;
    assign full_next   = (fill_next == FULL);
    // Masked-off bits always compare equal; an all-zero mask matches any full window.
    assign match_next  = full_next && (&((window_next ~^ pattern) | ~mask));

    // Window and fill registers; clears take priority over shifting.
    always_ff @(posedge clk) begin
        if (rst) begin
            window <= '0;
            fill   <= '0;
        end else begin
            if (clr_window)
                window <= '0;
            else
                window <= window_next;
            if (clr_fill)
                fill <= '0;
            else
                fill <= fill_next;
        end
    end

endmodule

// File: rtl/moore_seq_detector.sv
// Runtime-programmable Moore serial sequence detector with don't-care mask,
// overlap/non-overlap mode and a saturating match counter.
module moore_seq_detector
    import moore_det_pkg::*;
#(
    parameter int               PAT_W       = 4,
    parameter int               CNT_W       = 8,
    parameter logic [PAT_W-1:0] RST_PATTERN = PAT_W'(4'b1011),
    parameter logic [PAT_W-1:0] RST_MASK    = '1,
    parameter logic             RST_OVERLAP = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_we,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [PAT_W-1:0] cfg_mask,
    input  logic             cfg_overlap,
    input  logic             bit_valid,
    input  logic             bit_in,
    input  logic             clr_count,
    output logic             detect,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] match_count,
    output logic             count_sat
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state;
    state_t           state_next;
    logic [PAT_W-1:0] pattern;
    logic [PAT_W-1:0] mask;
    logic             overlap;
    logic             accept;
    logic             match_next;
    logic             full_next;
    logic             hit_event;
    logic             clr_fill;

    assign accept    = bit_valid & en & ~cfg_we & ~rst;
    assign hit_event = accept & match_next;
    // Non-overlap restarts the window count on the edge entering HIT.
    assign clr_fill  = cfg_we | ~en | (hit_event & ~overlap);

    moore_det_window #(.PAT_W(PAT_W)) u_window (
        .clk        (clk),
        .rst        (rst),
        .shift      (accept),
        .bit_in     (bit_in),
        .clr_window (cfg_we),
        .clr_fill   (clr_fill),
        .pattern    (pattern),
        .mask       (mask),
        .match_next (match_next),
        .full_next  (full_next)
    );

    // Configuration registers, loaded on cfg_we.
    always_ff @(posedge clk) begin
        if (rst) begin
            pattern <= RST_PATTERN;
            mask    <= RST_MASK;
            overlap <= RST_OVERLAP;
        end else if (cfg_we) begin
            pattern <= cfg_pattern;
            mask    <= cfg_mask;
            overlap <= cfg_overlap;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next-state logic: disable, then reconfigure, then accepted bit, then idle drift.
    always_comb begin
        state_next = state;
        if (!en)
            state_next = IDLE;
        else if (cfg_we)
            state_next = FILL;
        else if (accept)
            state_next = match_next ? HIT : (full_next ? ARMED : FILL);
        else begin
            case (state)
                IDLE:    state_next = FILL;
                HIT:     state_next = overlap ? ARMED : FILL;
                default: state_next = state;
            endcase
        end
    end

    // Saturating match counter with sticky overflow flag; clear beats a match.
    always_ff @(posedge clk) begin
        if (rst || clr_count) begin
            match_count <= '0;
            count_sat   <= 1'b0;
        end else if (hit_event) begin
            if (match_count == CNT_MAX)
                count_sat <= 1'b1;
            else
                match_count <= match_count + CNT_W'(1);
        end
    end

    assign detect  = (state == HIT);
    assign state_o = state;

endmodule
